alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - accumulator command sequencer driving an external 4-bit ALU
// Optional macro ALU_SEQ_STICKY_FLAGS_EN: C and V accumulate (OR) across repeat iterations.
module alu_sequencer #(
    parameter logic [3:0] ACC_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_fs,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_cnt,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_fs,
    input  logic [3:0] alu_y,
    input  logic [3:0] alu_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic [3:0] res_flags,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] acc, acc_nx;
    logic [3:0] flags, flags_nx;
    logic [3:0] b_reg, b_nx;
    logic [2:0] fs_reg, fs_nx;
    logic [1:0] iter, iter_nx;
    logic [3:0] exec_flags;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // C/V were cleared on command accept, so the first EXEC cycle effectively loads them.
    assign exec_flags = {flags[3:2] | alu_flags[3:2], alu_flags[1:0]};
`else
    assign exec_flags = alu_flags;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= ACC_RESET;
            flags  <= 4'h0;
            b_reg  <= 4'h0;
            fs_reg <= 3'h0;
            iter   <= 2'h0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            flags  <= flags_nx;
            b_reg  <= b_nx;
            fs_reg <= fs_nx;
            iter   <= iter_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        flags_nx  = flags;
        b_nx      = b_reg;
        fs_nx     = fs_reg;
        iter_nx   = iter;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_nx   = cmd_b;
                        flags_nx = {2'b00, cmd_b[3], cmd_b == 4'h0};
                        state_nx = DONE;
                    end else begin
                        fs_nx    = cmd_fs;
                        b_nx     = cmd_b;
                        iter_nx  = cmd_cnt;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                        flags_nx = {2'b00, flags[1:0]};
`endif
                        state_nx = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_nx   = alu_y;
                flags_nx = exec_flags;
                if (iter == 2'd0) begin
                    state_nx = DONE;
                end else begin
                    iter_nx = iter - 2'd1;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign alu_a     = acc;
    assign alu_b     = b_reg;
    assign alu_fs    = fs_reg;
    assign res_y     = acc;
    assign res_flags = flags;
    assign busy      = (state != IDLE);

endmodule
